// File: rtl/alu_pkg.sv
// Op codes, FSM states and operand-signedness helpers for the iterative M-extension unit.
package alu_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiplier and restoring divider
// sharing one 2*W working register; magnitudes are processed and the sign fixed at the end.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    Result,
    output logic                     Busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    muldiv_state_e  state;
    muldiv_op_e     op_q;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opnd;
    logic           neg;

    muldiv_op_e     op_in;
    logic           sa, sb, neg_in, div_zero, div_ovf;
    logic [W-1:0]   mag_a, mag_b, special;
    logic [W:0]     sum, rsh, trial;
    logic [2*W-1:0] acc_nxt, prod;
    logic [W-1:0]   quo, rem, res_fix;

    assign in_ready = (state == IDLE);
    assign Busy     = (state != IDLE);

    always_comb begin
        op_in    = muldiv_op_e'(Operation[2:0]);
        sa       = is_signed_a(op_in) && SrcA[W-1];
        sb       = is_signed_b(op_in) && SrcB[W-1];
        mag_a    = sa ? -SrcA : SrcA;
        mag_b    = sb ? -SrcB : SrcB;
        // Remainder takes the dividend's sign; everything else the product of signs.
        neg_in   = (op_in == MD_REM) ? sa : (sa ^ sb);
        div_zero = is_div(op_in) && (SrcB == '0);
        div_ovf  = (op_in inside {MD_DIV, MD_REM}) && (SrcA == MIN_VAL) && (SrcB == '1);
        if (div_zero)
            special = (op_in inside {MD_DIV, MD_DIVU}) ? '1 : SrcA;
        else
            special = (op_in == MD_DIV) ? MIN_VAL : '0;

        // Multiply: {hi,lo} with multiplier in lo; divide: {rem,quo} shifted left.
        sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        rsh   = acc[2*W-1:W-1];
        trial = rsh - {1'b0, opnd};
        if (is_div(op_q))
            acc_nxt = trial[W] ? {rsh[W-1:0], acc[W-2:0], 1'b0}
                               : {trial[W-1:0], acc[W-2:0], 1'b1};
        else
            acc_nxt = {sum, acc[W-1:1]};

        prod = neg ? -acc_nxt : acc_nxt;
        quo  = neg ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
        rem  = neg ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
        case (op_q)
            MD_MUL:                       res_fix = prod[W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res_fix = prod[2*W-1:W];
            MD_DIV, MD_DIVU:              res_fix = quo;
            default:                      res_fix = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= MD_MUL;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            neg       <= 1'b0;
            Result    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q <= op_in;
                    cnt  <= '0;
                    neg  <= neg_in;
                    opnd <= is_div(op_in) ? mag_b : mag_a;
                    acc  <= {{W{1'b0}}, (is_div(op_in) ? mag_a : mag_b)};
                    if (div_zero || div_ovf) begin
                        Result    <= special;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    // Last iteration: sign-fix the freshly computed value straight into Result.
                    if (cnt == CW'(W - 1)) begin
                        Result    <= res_fix;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed + random bench for alu_muldiv; expected results/latencies queued at issue, checked at out_valid.
module tb_alu_muldiv;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3,
                           OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, out_valid, out_ready, Busy;
    logic [W-1:0] SrcA, SrcB, Result;
    logic [2:0]   Operation;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int           lat_q[$];

    logic [2:0]   t_op  [12] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM,
                                 OP_DIVU, OP_REMU, OP_DIV, OP_REMU, OP_DIV, OP_REM};
    logic [W-1:0] t_a   [12] = '{32'd7, MIN, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                 32'd100, 32'd100, 32'd5, 32'd5, MIN, MIN};
    logic [W-1:0] t_b   [12] = '{32'hFFFFFFFD, MIN, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [W-1:0] t_exp [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, MIN, 32'd0};

    alu_muldiv #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .Busy(Busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [63:0] xa, xb, ya, yb;
        logic [63:0]        p;
        logic signed [W-1:0] q;
        logic [W-1:0]       r;
        xa = {{32{a[31]}}, a};
        xb = {{32{b[31]}}, b};
        ya = {32'b0, a};
        yb = {32'b0, b};
        p  = '0;
        q  = '0;
        r  = '0;
        case (op)
            OP_MUL:    begin p = xa * xb; r = p[31:0];  end
            OP_MULH:   begin p = xa * xb; r = p[63:32]; end
            OP_MULHSU: begin p = xa * yb; r = p[63:32]; end
            OP_MULHU:  begin p = ya * yb; r = p[63:32]; end
            OP_DIV: begin
                if (b == 0) r = '1;
                else if (a == MIN && b == '1) r = MIN;
                else begin q = $signed(a) / $signed(b); r = q; end
            end
            OP_DIVU: r = (b == 0) ? '1 : a / b;
            OP_REM: begin
                if (b == 0) r = a;
                else if (a == MIN && b == '1) r = '0;
                else begin q = $signed(a) % $signed(b); r = q; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic ovf;
        ovf = (op == OP_DIV || op == OP_REM) && a == MIN && b == '1;
        return (op[2] && (b == 0 || ovf)) ? 1 : W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return MIN;
            2: return '1;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Drive one request (DUT must be idle) and queue its expectation; operands scrambled after accept.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input bit poke);
        chk1("issue in_ready", in_ready, 1'b1);
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(exp_lat(op, a, b));
        @(posedge clk); #1;
        in_valid  = poke;
        SrcA      = $urandom;
        SrcB      = $urandom;
        Operation = 3'($urandom);
    endtask

    task automatic collect(input string tag, input int hold, input bit consume);
        int n;
        logic [W-1:0] e;
        int el;
        n = 1;
        forever begin
            @(negedge clk);
            if (out_valid || n > 100) break;
            @(posedge clk);
            n++;
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        chk1({tag, " out_valid"}, out_valid, 1'b1);
        chk({tag, " result"}, Result, e);
        chk({tag, " latency"}, n, el);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold result"}, Result, e);
            chk1({tag, " hold valid"}, out_valid, 1'b1);
            chk1({tag, " hold in_ready"}, in_ready, 1'b0);
        end
        if (consume) begin
            @(negedge clk);
            out_ready = 1'b1;
            chk1({tag, " done in_ready"}, in_ready, 1'b0);
            @(posedge clk); #1;
            out_ready = 1'b0;
            in_valid  = 1'b0;
            chk1({tag, " consumed valid"}, out_valid, 1'b0);
            chk1({tag, " consumed in_ready"}, in_ready, 1'b1);
            chk1({tag, " consumed busy"}, Busy, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        SrcA = '0; SrcB = '0; Operation = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk1("reset in_ready", in_ready, 1'b1);
        chk1("reset out_valid", out_valid, 1'b0);
        chk1("reset busy", Busy, 1'b0);
        chk("reset result", Result, '0);

        for (int i = 0; i < 12; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_exp[i], 1'b0);
            chk1($sformatf("dir%0d busy", i), Busy, 1'b1);
            collect($sformatf("dir%0d", i), 0, 1'b1);
        end

        // Stalled consumer with in_valid held high through CALC and DONE.
        issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
        collect("hold mulhu", 10, 1'b1);
        issue(OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);
        collect("hold div0", 3, 1'b1);

        // Next request offered in the consume cycle is only taken once back in IDLE.
        issue(OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0);
        collect("b2b first", 0, 1'b0);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; Operation = OP_DIVU; SrcA = 32'd100; SrcB = 32'd7;
        chk1("b2b in_ready in done", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk1("b2b valid dropped", out_valid, 1'b0);
        chk1("b2b idle", in_ready, 1'b1);
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
        collect("b2b second", 0, 1'b1);

        // Reset at CALC iteration 10.
        Operation = OP_MUL; SrcA = 32'd1234; SrcB = 32'd5678; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk1("pre-reset busy", Busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk1("abort in_ready", in_ready, 1'b1);
        chk1("abort out_valid", out_valid, 1'b0);
        chk1("abort busy", Busy, 1'b0);
        chk("abort result", Result, '0);
        issue(OP_MUL, 32'h00003039, 32'hFFFF0000, 32'hCFC70000, 1'b0);
        collect("post-reset mul", 0, 1'b1);

        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 20; k++) begin
                a = pick();
                b = pick();
                issue(3'(op), a, b, ref_model(3'(op), a, b), k[0]);
                collect($sformatf("rand op%0d #%0d", op, k), $urandom_range(0, 2), 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
